// File: rtl/lcd_timing_if.sv
// lcd_timing_if: raster coordinates, data-enable and sync outputs of lcd_timing_gen.
interface lcd_timing_if;
    logic [8:0] o_x;
    logic [8:0] o_y;
    logic       o_hde;
    logic       o_vde;
    logic       o_frame_start;
    logic       o_hsync;
    logic       o_vsync;
    logic       o_den;
    modport master (
        output o_x, o_y, o_hde, o_vde, o_frame_start, o_hsync, o_vsync, o_den
    );
    modport slave (
        input o_x, o_y, o_hde, o_vde, o_frame_start, o_hsync, o_vsync, o_den
    );
endinterface

// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: pixel-clock raster timing for an RGB LCD, with sync/DE delayed to match ROM latency.
module lcd_timing_gen #(
    parameter int H_ACTIVE = 480,
    parameter int H_FP     = 8,
    parameter int H_SYNC   = 4,
    parameter int H_BP     = 43,
    parameter int V_ACTIVE = 272,
    parameter int V_FP     = 8,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 12,
    parameter int SYNC_POL = 0,
    parameter int DELAY    = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    lcd_timing_if.master lcd
);
    localparam int   H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int   V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int   HS_BEG  = H_ACTIVE + H_FP;
    localparam int   HS_END  = HS_BEG + H_SYNC;
    localparam int   VS_BEG  = V_ACTIVE + V_FP;
    localparam int   VS_END  = VS_BEG + V_SYNC;
    localparam logic POL     = SYNC_POL != 0;

    if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_porch
        $error("lcd_timing_gen: porch and sync widths must be at least 1");
    end
    if (H_ACTIVE < 1 || H_ACTIVE > 512 || V_ACTIVE < 1 || V_ACTIVE > 512) begin : g_bad_active
        $error("lcd_timing_gen: active size must fit the 9-bit coordinates");
    end
    if (H_TOTAL > 1023 || V_TOTAL > 1023) begin : g_bad_total
        $error("lcd_timing_gen: H_TOTAL and V_TOTAL must not exceed 1023");
    end
    if (DELAY < 0 || DELAY > 7 || SYNC_POL < 0 || SYNC_POL > 1) begin : g_bad_misc
        $error("lcd_timing_gen: DELAY must be 0..7 and SYNC_POL 0 or 1");
    end

    logic [9:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic       h_wrap, hde_d, vde_d, fs_d;
    logic       hde_q, vde_q, fs_q;
    logic [8:0] x_d, y_d, x_q, y_q;
    // {hsync, vsync, de} carried as active-high flags; polarity is applied at the pins
    logic [2:0] sync_d, sync_q, sync_o;

    always_comb begin
        h_wrap  = h_cnt_q == 10'(H_TOTAL - 1);
        h_cnt_d = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
        v_cnt_d = !h_wrap ? v_cnt_q : (v_cnt_q == 10'(V_TOTAL - 1)) ? 10'd0 : v_cnt_q + 10'd1;
        hde_d   = h_cnt_q < 10'(H_ACTIVE);
        vde_d   = v_cnt_q < 10'(V_ACTIVE);
        x_d     = hde_d ? h_cnt_q[8:0] : 9'd0;
        y_d     = vde_d ? v_cnt_q[8:0] : 9'd0;
        fs_d    = h_cnt_q == 10'd0 && v_cnt_q == 10'd0;
        sync_d  = {h_cnt_q >= 10'(HS_BEG) && h_cnt_q < 10'(HS_END),
                   v_cnt_q >= 10'(VS_BEG) && v_cnt_q < 10'(VS_END),
                   hde_d && vde_d};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            hde_q   <= 1'b0;
            vde_q   <= 1'b0;
            fs_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            sync_q  <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            hde_q   <= hde_d;
            vde_q   <= vde_d;
            fs_q    <= fs_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sync_q  <= sync_d;
        end
    end

    if (DELAY == 0) begin : g_nodly
        assign sync_o = sync_q;
    end else begin : g_dly
        logic [2:0] dly_q [DELAY];
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                for (int i = 0; i < DELAY; i++) dly_q[i] <= '0;
            end else begin
                dly_q[0] <= sync_q;
                for (int i = 1; i < DELAY; i++) dly_q[i] <= dly_q[i-1];
            end
        end
        assign sync_o = dly_q[DELAY-1];
    end

    assign lcd.o_x           = x_q;
    assign lcd.o_y           = y_q;
    assign lcd.o_hde         = hde_q;
    assign lcd.o_vde         = vde_q;
    assign lcd.o_frame_start = fs_q;
    assign lcd.o_hsync       = sync_o[2] ~^ POL;
    assign lcd.o_vsync       = sync_o[1] ~^ POL;
    assign lcd.o_den         = sync_o[0];
endmodule

// File: tb/tb_lcd_timing_gen.sv
// tb_lcd_timing_gen: checks full-size and reduced-size timing generators against a raster-position model.
module tb_lcd_timing_gen;
    typedef struct {int ha, hf, hs, hb, va, vf, vs, vb, dly, pol;} cfg_t;
    typedef struct packed {logic [8:0] x, y; logic hde, vde, fs, hs, vs, de;} stg_t;

    localparam int S_HA = 16, S_HF = 2, S_HS = 3, S_HB = 4;
    localparam int S_VA = 6, S_VF = 2, S_VS = 2, S_VB = 3;
    localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
    localparam int S_VT = S_VA + S_VF + S_VS + S_VB;
    localparam int S_FT = S_HT * S_VT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    longint      k;
    int          checks = 0;
    int          failures = 0;
    cfg_t        cfg [4];
    logic [23:0] obs [4];

    always #5 clk = ~clk;
    // k = number of rising edges since reset was released
    always @(posedge clk or negedge rst_n) if (!rst_n) k <= 0; else k <= k + 1;

    lcd_timing_if if_def ();
    lcd_timing_if if_s0 ();
    lcd_timing_if if_s3 ();
    lcd_timing_if if_s7 ();

    lcd_timing_gen u_def (.i_clk(clk), .i_rst_n(rst_n), .lcd(if_def));
    lcd_timing_gen #(.H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB), .V_ACTIVE(S_VA), .V_FP(S_VF),
        .V_SYNC(S_VS), .V_BP(S_VB), .SYNC_POL(0), .DELAY(0)) u_s0 (.i_clk(clk), .i_rst_n(rst_n), .lcd(if_s0));
    lcd_timing_gen #(.H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB), .V_ACTIVE(S_VA), .V_FP(S_VF),
        .V_SYNC(S_VS), .V_BP(S_VB), .SYNC_POL(0), .DELAY(3)) u_s3 (.i_clk(clk), .i_rst_n(rst_n), .lcd(if_s3));
    lcd_timing_gen #(.H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB), .V_ACTIVE(S_VA), .V_FP(S_VF),
        .V_SYNC(S_VS), .V_BP(S_VB), .SYNC_POL(1), .DELAY(7)) u_s7 (.i_clk(clk), .i_rst_n(rst_n), .lcd(if_s7));

    assign obs[0] = {if_def.o_x, if_def.o_y, if_def.o_hde, if_def.o_vde, if_def.o_frame_start, if_def.o_hsync, if_def.o_vsync, if_def.o_den};
    assign obs[1] = {if_s0.o_x, if_s0.o_y, if_s0.o_hde, if_s0.o_vde, if_s0.o_frame_start, if_s0.o_hsync, if_s0.o_vsync, if_s0.o_den};
    assign obs[2] = {if_s3.o_x, if_s3.o_y, if_s3.o_hde, if_s3.o_vde, if_s3.o_frame_start, if_s3.o_hsync, if_s3.o_vsync, if_s3.o_den};
    assign obs[3] = {if_s7.o_x, if_s7.o_y, if_s7.o_hde, if_s7.o_vde, if_s7.o_frame_start, if_s7.o_hsync, if_s7.o_vsync, if_s7.o_den};

    // Stage-1 view after edge kk: edge 1 shows raster position 0, positions advance one per clock.
    function automatic stg_t stage(cfg_t c, longint kk);
        stg_t r = '0;
        longint ht = c.ha + c.hf + c.hs + c.hb;
        longint vt = c.va + c.vf + c.vs + c.vb;
        longint p, h, v;
        if (kk < 1) return r;
        p = (kk - 1) % (ht * vt);
        h = p % ht;
        v = p / ht;
        r.hde = h < c.ha;
        r.vde = v < c.va;
        r.x = r.hde ? 9'(h) : 9'd0;
        r.y = r.vde ? 9'(v) : 9'd0;
        r.fs = p == 0;
        r.hs = h >= c.ha + c.hf && h < c.ha + c.hf + c.hs;
        r.vs = v >= c.va + c.vf && v < c.va + c.vf + c.vs;
        r.de = r.hde && r.vde;
        return r;
    endfunction

    function automatic logic [23:0] expect_vec(cfg_t c, longint kk);
        stg_t s = stage(c, kk);
        stg_t d = stage(c, kk - c.dly);
        logic p = c.pol[0];
        return {s.x, s.y, s.hde, s.vde, s.fs, d.hs ? p : !p, d.vs ? p : !p, d.de};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            logic [23:0] e = {21'd0, !cfg[i].pol[0], !cfg[i].pol[0], 1'b0};
            checks++;
            if (obs[i] !== e) begin failures++; $display("FAIL reset_state[%0d] got=%h want=%h", i, obs[i], e); end
        end
    endtask

    task automatic test_first_edges();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (obs[0][23:3] !== {9'd0, 9'd0, 3'b111}) begin
            failures++; $display("FAIL edge1_xy_de_fs got=%h want=%h", obs[0][23:3], {9'd0, 9'd0, 3'b111});
        end
        checks++;
        if (obs[0][2:0] !== 3'b110) begin failures++; $display("FAIL edge1_sync_den got=%b want=110", obs[0][2:0]); end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (obs[i][3] !== 1'b1) begin failures++; $display("FAIL edge1_fs[%0d] got=%b want=1", i, obs[i][3]); end
        end
        @(negedge clk);
        checks++;
        if ({obs[0][23:15], obs[0][3], obs[0][2:0]} !== {9'd1, 1'b0, 3'b111}) begin
            failures++; $display("FAIL edge2_x_fs_den got=%h want=%h", {obs[0][23:15], obs[0][3], obs[0][2:0]}, {9'd1, 1'b0, 3'b111});
        end
    endtask

    task automatic test_sweep(string tag, int n);
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < 4; i++) begin
                logic [23:0] e = expect_vec(cfg[i], k);
                checks++;
                if (obs[i] !== e) begin
                    failures++; $display("FAIL %s[%0d] k=%0d got=%h want=%h", tag, i, k, obs[i], e);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_frames();
        int n = 0, c_fs = -1, den = 0, hde = 0, hsl = 0, vsl = 0;
        int hde_rise = 0, hde_fall = -100, hs_fall = -1;
        logic p_hde, p_hs;
        while (obs[1][3] !== 1'b1 && n < 2 * S_FT) begin @(negedge clk); n++; end
        checks++;
        if (obs[1][3] !== 1'b1) begin failures++; $display("FAIL frame_start_wait got=%b want=1", obs[1][3]); end
        p_hde = obs[1][5];
        p_hs = obs[1][2];
        for (int c = 0; c < 2 * S_FT; c++) begin
            logic hde_n = obs[1][5], hs_n = obs[1][2];
            if (obs[1][3]) begin
                if (c_fs >= 0) begin
                    checks++;
                    if (c - c_fs != S_FT) begin failures++; $display("FAIL frame_period got=%0d want=%0d", c - c_fs, S_FT); end
                end
                c_fs = c;
            end
            den += int'(obs[1][0]);
            hde += int'(hde_n);
            hsl += int'(!hs_n);
            vsl += int'(!obs[1][1]);
            if (!p_hde && hde_n) hde_rise = c;
            if (p_hde && !hde_n) begin
                hde_fall = c;
                checks++;
                if (c - hde_rise != S_HA) begin failures++; $display("FAIL hde_width got=%0d want=%0d", c - hde_rise, S_HA); end
            end
            if (p_hs && !hs_n) begin
                hs_fall = c;
                checks++;
                if (c - hde_fall != S_HF) begin failures++; $display("FAIL hsync_offset got=%0d want=%0d", c - hde_fall, S_HF); end
            end
            if (!p_hs && hs_n && hs_fall >= 0) begin
                checks++;
                if (c - hs_fall != S_HS) begin failures++; $display("FAIL hsync_width got=%0d want=%0d", c - hs_fall, S_HS); end
            end
            p_hde = hde_n;
            p_hs = hs_n;
            @(negedge clk);
        end
        checks++;
        if (den != 2 * S_HA * S_VA) begin failures++; $display("FAIL den_count got=%0d want=%0d", den, 2 * S_HA * S_VA); end
        checks++;
        if (hde != 2 * S_VT * S_HA) begin failures++; $display("FAIL hde_count got=%0d want=%0d", hde, 2 * S_VT * S_HA); end
        checks++;
        if (hsl != 2 * S_VT * S_HS) begin failures++; $display("FAIL hsync_low_count got=%0d want=%0d", hsl, 2 * S_VT * S_HS); end
        checks++;
        if (vsl != 2 * S_VS * S_HT) begin failures++; $display("FAIL vsync_low_count got=%0d want=%0d", vsl, 2 * S_VS * S_HT); end
    endtask

    task automatic test_delay_align();
        for (int i = 2; i < 4; i++) begin
            int ta = -1, tb = -1;
            logic pa = obs[i][5] & obs[i][4], pd = obs[i][0];
            for (int c = 0; c < S_FT + 20 && tb < 0; c++) begin
                logic a = obs[i][5] & obs[i][4];
                if (!pa && a && ta < 0) ta = c;
                if (ta >= 0 && !pd && obs[i][0]) tb = c;
                pa = a;
                pd = obs[i][0];
                @(negedge clk);
            end
            checks++;
            if (ta < 0 || tb < 0 || tb - ta != cfg[i].dly) begin
                failures++; $display("FAIL den_delay[%0d] got=%0d want=%0d", i, tb - ta, cfg[i].dly);
            end
        end
    endtask

    task automatic test_sync_pol();
        int hs_lo0 = 0, hs_hi7 = 0, vs_hi7 = 0;
        for (int c = 0; c < S_FT; c++) begin
            hs_lo0 += int'(!obs[1][2]);
            hs_hi7 += int'(obs[3][2]);
            vs_hi7 += int'(obs[3][1]);
            @(negedge clk);
        end
        checks++;
        if (hs_lo0 != S_VT * S_HS) begin failures++; $display("FAIL pol0_hsync_active got=%0d want=%0d", hs_lo0, S_VT * S_HS); end
        checks++;
        if (hs_hi7 != S_VT * S_HS) begin failures++; $display("FAIL pol1_hsync_active got=%0d want=%0d", hs_hi7, S_VT * S_HS); end
        checks++;
        if (vs_hi7 != S_VS * S_HT) begin failures++; $display("FAIL pol1_vsync_active got=%0d want=%0d", vs_hi7, S_VS * S_HT); end
    endtask

    task automatic test_async_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * 535 + 301) @(negedge clk);
        checks++;
        if (obs[0][23:15] !== 9'd300 || obs[0][14:6] !== 9'd2) begin
            failures++; $display("FAIL pre_reset_pos got=%0d,%0d want=300,2", obs[0][23:15], obs[0][14:6]);
        end
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            logic [23:0] e = {21'd0, !cfg[i].pol[0], !cfg[i].pol[0], 1'b0};
            checks++;
            if (obs[i] !== e) begin failures++; $display("FAIL async_reset[%0d] got=%h want=%h", i, obs[i], e); end
        end
        repeat ($urandom_range(1, 3)) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs[i][23:3] !== {18'd0, 3'b111}) begin
                failures++; $display("FAIL restart[%0d] got=%h want=%h", i, obs[i][23:3], {18'd0, 3'b111});
            end
        end
    endtask

    task automatic test_back_to_back();
        repeat (4) begin
            int n = int'($urandom_range(3, 400));
            for (int c = 0; c < n; c++) begin
                for (int i = 0; i < 4; i++) begin
                    logic [23:0] e = expect_vec(cfg[i], k);
                    checks++;
                    if (obs[i] !== e) begin failures++; $display("FAIL b2b_run[%0d] k=%0d got=%h want=%h", i, k, obs[i], e); end
                end
                @(negedge clk);
            end
            #($urandom_range(1, 3)) rst_n = 1'b0;
            #1;
            for (int i = 0; i < 4; i++) begin
                logic [23:0] e = {21'd0, !cfg[i].pol[0], !cfg[i].pol[0], 1'b0};
                checks++;
                if (obs[i] !== e) begin failures++; $display("FAIL b2b_reset[%0d] got=%h want=%h", i, obs[i], e); end
            end
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
        end
    endtask

    initial begin
        cfg[0] = '{480, 8, 4, 43, 272, 8, 4, 12, 1, 0};
        cfg[1] = '{S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, 0, 0};
        cfg[2] = '{S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, 3, 0};
        cfg[3] = '{S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, 7, 1};
        test_reset();
        test_first_edges();
        test_sweep("sweep_lines", 1700);
        test_frames();
        test_delay_align();
        test_sync_pol();
        test_async_reset();
        test_sweep("sweep_after_reset", 600);
        test_back_to_back();
        test_sweep("sweep_final", 200);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lcd_timing_gen.md
Name: lcd_timing_gen

Overview:
- Single-clock raster timing generator for the 480x272 RGB LCD panel.
- Produces x/y pixel coordinates for image memory addressing. Also produces HSYNC, VSYNC and DEN, delayed by a programmable number of pixel clocks so they line up with the pixel data coming out of the synchronous ROM.
- Sits directly upstream of the pixel/ROM readout stage and clocks everything from the pixel clock, so the vertical counter is no longer clocked from HSYNC.

Parameters:
- H_ACTIVE, 480, active pixels per line
- H_FP, 8, horizontal front porch (clocks)
- H_SYNC, 4, hsync pulse width (clocks)
- H_BP, 43, horizontal back porch (clocks)
- V_ACTIVE, 272, active lines per frame
- V_FP, 8, vertical front porch (lines)
- V_SYNC, 4, vsync pulse width (lines)
- V_BP, 12, vertical back porch (lines)
- SYNC_POL, 0, sync active level: 0 = active-low, 1 = active-high
- DELAY, 1, extra pixel-clock stages applied to hsync/vsync/den (0..7) to match downstream memory latency

Ports:
- i_clk  in  1  pixel clock (LCD_CLK)
- i_rst_n  in  1  asynchronous active-low reset
- o_x  out  9  pixel column, valid while o_hde=1
- o_y  out  9  pixel row, valid while o_vde=1
- o_hde  out  1  horizontal active region (undelayed)
- o_vde  out  1  vertical active region (undelayed)
- o_frame_start  out  1  one-cycle pulse at pixel (0,0), aligned with o_x/o_y
- o_hsync  out  1  delayed horizontal sync, level per SYNC_POL
- o_vsync  out  1  delayed vertical sync, level per SYNC_POL
- o_den  out  1  delayed data enable (hde & vde)

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (535); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (296).
- Counters: h_cnt and v_cnt are 10 bits, reset asynchronously to 0.
  - h_cnt increments every clock and wraps at H_TOTAL-1 to 0.
  - v_cnt increments only on the h_cnt wrap cycle and wraps at V_TOTAL-1 to 0.
  - Line order (h_cnt): active [0,H_ACTIVE), front porch, sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC) = [488,492), back porch.
  - Frame order (v_cnt): same ordering; vsync lines [280,284). vsync covers entire lines, changing on the h wrap.
- Stage 1 (registered decode, 1 clock after the counters):
  - o_hde = h_cnt<H_ACTIVE; o_vde = v_cnt<V_ACTIVE.
  - o_x = h_cnt[8:0] when hde, else 0; o_y = v_cnt[8:0] when vde, else 0.
  - o_frame_start = (h_cnt==0 && v_cnt==0).
  - Internal hs/vs/de are decoded in the same stage.
- Stage 2..: hs/vs/de pass through a DELAY-deep shift register to produce o_hsync, o_vsync and o_den.
  - With DELAY=0 they are combinationally equal to the stage-1 values, i.e. aligned with o_x/o_y.
  - With DELAY=N, o_den rises exactly N clocks after o_hde&o_vde rises.
- Reset (asynchronous, any time including mid-line or mid-frame):
  - o_x, o_y, o_hde, o_vde, o_frame_start, o_den = 0.
  - o_hsync and o_vsync = inactive level (~SYNC_POL).
  - The delay line is filled with inactive values.
- After reset release:
  - The first rising edge registers decode of counter value (0,0), so o_frame_start=1 on edge 1.
  - The counters advance from that same edge.
  - No partial-frame glitch: the first frame is complete.
- Boundaries:
  - Last pixel (479, y) is followed by o_hde=0 on the next clock.
  - Line 271 → 272 drops o_vde at the h wrap.
  - Frame wrap (h=534, v=295) → (0,0) produces o_frame_start on the following stage-1 cycle.
- Parameter rules: all porch/sync values must be ≥1; H_TOTAL and V_TOTAL must be ≤1023; DELAY must be ≤7. Out-of-range values are a static error, enforced by an elaboration-time check.
- Timing invariants: frame period = H_TOTAL*V_TOTAL = 158360 clocks; hsync width = H_SYNC clocks; vsync width = V_SYNC*H_TOTAL clocks.

Test Plan:
- Reset then release, default params: o_frame_start=1 on the 1st edge with o_x=0, o_y=0, o_hde=1. o_den=1 one clock later (DELAY=1). o_hsync and o_vsync stay 1 (inactive low).
- Run 2 frames: o_frame_start period = 158360 clocks. Per line, o_hde high for 480 clocks and o_hsync low for 4 clocks, starting 8 clocks after o_hde falls. Per frame, o_vsync low for 2140 clocks. o_den count per frame = 130560.
- Sweep o_x/o_y: o_x steps 0..479 monotonically each active line; o_y steps 0..271; neither exceeds 479/271. Both are 0 while their DE is low.
- Assert i_rst_n asynchronously mid-line at h=300, v=100 (no clock edge): outputs go immediately to reset values. On release, the sequence restarts at (0,0).
- Run with DELAY=0, 3 and 7: o_hsync, o_vsync and o_den equal the stage-1 decode delayed by exactly 0, 3 and 7 clocks respectively. Waveform is otherwise identical.
- Run with SYNC_POL=1: o_hsync and o_vsync polarity is inverted; pulse positions and widths are unchanged; reset level is 0.
